// File: rtl/eight_bit_exp_decay_lookup_pkg.sv
// eight_bit_exp_decay_lookup_pkg: envelope amplitude constants and the exp_table decay ROM (x phase in, f(x) out)
package eight_bit_exp_decay_lookup_pkg;
  localparam int ENV_AMP_W = 8;
  localparam logic [ENV_AMP_W-1:0] ENV_FULL_SCALE = 8'd255;
  function automatic logic [7:0] exp_table(input logic [7:0] x);
    logic [7:0] y;
    case (x) inside
      8'd0: y = 8'd255;  8'd1: y = 8'd250;  8'd2: y = 8'd245;  8'd3: y = 8'd240;
      8'd4: y = 8'd236;  8'd5: y = 8'd231;  8'd6: y = 8'd227;  8'd7: y = 8'd222;
      8'd8: y = 8'd218;  8'd9: y = 8'd213;  8'd10: y = 8'd209; 8'd11: y = 8'd205;
      8'd12: y = 8'd201; 8'd13: y = 8'd197; 8'd14: y = 8'd193; 8'd15: y = 8'd190;
      8'd16: y = 8'd186; 8'd17: y = 8'd182; 8'd18: y = 8'd179; 8'd19: y = 8'd175;
      8'd20: y = 8'd172; 8'd21: y = 8'd168; 8'd22: y = 8'd165; 8'd23: y = 8'd162;
      8'd24: y = 8'd159; 8'd25: y = 8'd156; 8'd26: y = 8'd152; 8'd27: y = 8'd149;
      8'd28: y = 8'd147; 8'd29: y = 8'd144; 8'd30: y = 8'd141; 8'd31: y = 8'd138;
      8'd32: y = 8'd135; 8'd33: y = 8'd133; 8'd34: y = 8'd130; 8'd35: y = 8'd128;
      8'd36: y = 8'd125; 8'd37: y = 8'd123; 8'd38: y = 8'd120; 8'd39: y = 8'd118;
      8'd40: y = 8'd115; 8'd41: y = 8'd113; 8'd42: y = 8'd111; 8'd43: y = 8'd109;
      8'd44: y = 8'd107; 8'd45: y = 8'd105; 8'd46: y = 8'd102; 8'd47: y = 8'd100;
      8'd48: y = 8'd98;  8'd49: y = 8'd96;  8'd50: y = 8'd95;  8'd51: y = 8'd93;
      8'd52: y = 8'd91;  8'd53: y = 8'd89;  8'd54: y = 8'd87;  8'd55: y = 8'd86;
      8'd56: y = 8'd84;  8'd57: y = 8'd82;  8'd58: y = 8'd81;  8'd59: y = 8'd79;
      8'd60: y = 8'd77;  8'd61: y = 8'd76;  8'd62: y = 8'd74;  8'd63: y = 8'd73;
      8'd64: y = 8'd71;  8'd65: y = 8'd70;  8'd66: y = 8'd69;  8'd67: y = 8'd67;
      8'd68: y = 8'd66;  8'd69: y = 8'd65;  8'd70: y = 8'd63;  8'd71: y = 8'd62;
      8'd72: y = 8'd61;  8'd73: y = 8'd60;  8'd74: y = 8'd58;  8'd75: y = 8'd57;
      8'd76: y = 8'd56;  8'd77: y = 8'd55;  8'd78: y = 8'd54;  8'd79: y = 8'd53;
      8'd80: y = 8'd52;  8'd81: y = 8'd51;  8'd82: y = 8'd50;  8'd83: y = 8'd49;
      8'd84: y = 8'd48;  8'd85: y = 8'd47;  8'd86: y = 8'd46;  8'd87: y = 8'd45;
      8'd88: y = 8'd44;  8'd89: y = 8'd43;  8'd90: y = 8'd42;  [8'd91:8'd92]: y = 8'd41;
      8'd93: y = 8'd40;  8'd94: y = 8'd39;  8'd95: y = 8'd38;  [8'd96:8'd97]: y = 8'd37;
      8'd98: y = 8'd36;  8'd99: y = 8'd35;  [8'd100:8'd101]: y = 8'd34; 8'd102: y = 8'd33;
      [8'd103:8'd104]: y = 8'd32; 8'd105: y = 8'd31; [8'd106:8'd107]: y = 8'd30;
      [8'd108:8'd109]: y = 8'd29; 8'd110: y = 8'd28; [8'd111:8'd112]: y = 8'd27;
      [8'd113:8'd114]: y = 8'd26; [8'd115:8'd116]: y = 8'd25; [8'd117:8'd118]: y = 8'd24;
      [8'd119:8'd120]: y = 8'd23; [8'd121:8'd122]: y = 8'd22; [8'd123:8'd124]: y = 8'd21;
      [8'd125:8'd127]: y = 8'd20; [8'd128:8'd129]: y = 8'd19; [8'd130:8'd132]: y = 8'd18;
      [8'd133:8'd134]: y = 8'd17; [8'd135:8'd137]: y = 8'd16; [8'd138:8'd140]: y = 8'd15;
      [8'd141:8'd144]: y = 8'd14; [8'd145:8'd147]: y = 8'd13; [8'd148:8'd151]: y = 8'd12;
      [8'd152:8'd155]: y = 8'd11; [8'd156:8'd159]: y = 8'd10; [8'd160:8'd164]: y = 8'd9;
      [8'd165:8'd169]: y = 8'd8;  [8'd170:8'd175]: y = 8'd7;  [8'd176:8'd182]: y = 8'd6;
      [8'd183:8'd189]: y = 8'd5;  [8'd190:8'd198]: y = 8'd4;  [8'd199:8'd209]: y = 8'd3;
      [8'd210:8'd223]: y = 8'd2;  [8'd224:8'd242]: y = 8'd1;  [8'd243:8'd255]: y = 8'd0;
      default: y = 8'd0;
    endcase
    return y;
  endfunction
endpackage

// File: rtl/eight_bit_exp_decay_lookup_if.sv
// eight_bit_exp_decay_lookup_if: phase/amplitude bus; master drives din and reads dout, slave the reverse
interface eight_bit_exp_decay_lookup_if;
  import eight_bit_exp_decay_lookup_pkg::*;
  logic [ENV_AMP_W-1:0] din;
  logic [ENV_AMP_W-1:0] dout;
  modport master (output din, input dout);
  modport slave (input din, output dout);
endinterface

// File: rtl/eight_bit_exp_decay_lookup.sv
// eight_bit_exp_decay_lookup: registered exp-decay ROM; clk, rst (sync high, loads full scale), bus.din phase -> bus.dout = f(din) one cycle later
module eight_bit_exp_decay_lookup
  import eight_bit_exp_decay_lookup_pkg::*;
(
  input logic clk,
  input logic rst,
  eight_bit_exp_decay_lookup_if.slave bus
);
  always_ff @(posedge clk)
    bus.dout <= rst ? ENV_FULL_SCALE : exp_table(bus.din);
endmodule

// File: tb/tb_eight_bit_exp_decay_lookup.sv
// tb_eight_bit_exp_decay_lookup: checks the decay ROM against the closed-form curve with directed and random phases
module tb_eight_bit_exp_decay_lookup;
  logic clk;
  logic rst;
  int total;
  int bad;
  eight_bit_exp_decay_lookup_if bus();
  eight_bit_exp_decay_lookup dut (.clk(clk), .rst(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int model(input int x);
    real k;
    real v;
    k = 5.0;
    v = 255.0 * ($exp(-k * x / 255.0) - $exp(-k)) / (1.0 - $exp(-k));
    return int'($floor(v + 0.5));
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    int ref_din [5];
    int ref_val [5];
    logic [7:0] prev;
    int d;
    logic r;
    ref_din = '{51, 102, 128, 153, 204};
    ref_val = '{93, 33, 19, 11, 3};
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.din = 8'h80;
    tick();
    check("reset_hold1", bus.dout, 8'd255);
    tick();
    check("reset_hold2", bus.dout, 8'd255);
    rst = 1'b0;
    tick();
    check("reset_release", bus.dout, 8'd19);
    bus.din = 8'd0;
    tick();
    check("endpoint_0", bus.dout, 8'd255);
    bus.din = 8'd255;
    tick();
    check("endpoint_255", bus.dout, 8'd0);
    for (int i = 0; i < 5; i++) begin
      bus.din = 8'(ref_din[i]);
      tick();
      check($sformatf("refpoint_%0d", ref_din[i]), bus.dout, 8'(ref_val[i]));
    end
    prev = 8'd255;
    for (int i = 0; i < 256; i++) begin
      bus.din = 8'(i);
      tick();
      check($sformatf("sweep_%0d", i), bus.dout, 8'(model(i)));
      check($sformatf("monotonic_%0d", i), {7'd0, bus.dout <= prev}, 8'd1);
      prev = bus.dout;
    end
    for (int i = 0; i < 16; i++) begin
      bus.din = i[0] ? 8'd255 : 8'd0;
      tick();
      check($sformatf("toggle_%0d", i), bus.dout, i[0] ? 8'd0 : 8'd255);
    end
    for (int i = 90; i < 111; i++) begin
      bus.din = 8'(i);
      rst = (i == 100);
      tick();
      check($sformatf("midreset_%0d", i), bus.dout, (i == 100) ? 8'd255 : 8'(model(i)));
    end
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      d = int'($urandom_range(255, 0));
      r = ($urandom_range(15, 0) == 0);
      bus.din = 8'(d);
      rst = r;
      tick();
      check($sformatf("random_%0d_din%0d_rst%0d", i, d, r), bus.dout, r ? 8'd255 : 8'(model(d)));
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
